// File: rtl/id_stage_hazard_if.sv
// Decode-stage bus: fetch/control inputs, writeback port, and the registered ID/EX bundle.
interface id_stage_hazard_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 6,
    parameter int CTRL_W = 12
);
    logic              in_valid;
    logic [DATA_W-1:0] pc;
    logic [31:0]       instruction;
    logic [CTRL_W-1:0] ctrl;
    logic              flush;
    logic              hold;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              stall;
    logic              out_valid;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_rd1;
    logic [DATA_W-1:0] out_rd2;
    logic [DATA_W-1:0] out_imm;
    logic [REG_AW-1:0] out_rd;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, pc, instruction, ctrl, flush, hold, wb_we, wb_rd, wb_data,
        input  stall, out_valid, out_pc, out_rd1, out_rd2, out_imm, out_rd, out_ctrl
    );
    modport slave (
        input  in_valid, pc, instruction, ctrl, flush, hold, wb_we, wb_rd, wb_data,
        output stall, out_valid, out_pc, out_rd1, out_rd2, out_imm, out_rd, out_ctrl
    );
endinterface

// File: rtl/id_stage_hazard.sv
// Decode stage: register file with writeback bypass, ID/EX buffer, load-use stall.
module id_stage_hazard #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 6,
    parameter int IMM_W     = 22,
    parameter int CTRL_W    = 12,
    parameter int CTRL_REGW = 0,
    parameter int CTRL_MEMR = 1,
    parameter int CTRL_SVPC = 2
) (
    input logic             clk,
    input logic             rst_n,
    id_stage_hazard_if.slave bus
);
    localparam int NREG = 2 ** REG_AW;

    if (CTRL_REGW >= CTRL_W || CTRL_MEMR >= CTRL_W || CTRL_SVPC >= CTRL_W) begin : g_bad_ctrl
        $error("ctrl bit index out of range");
    end

    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] rs_val, rt_val, op1, imm;
    logic              svpc, haz;
    logic              unused_instr_hi;

    // rd sits just below bit 28; rs and rt follow contiguously beneath it
    assign rd  = bus.instruction[27 -: REG_AW];
    assign rs  = bus.instruction[27-REG_AW -: REG_AW];
    assign rt  = bus.instruction[27-2*REG_AW -: REG_AW];
    assign unused_instr_hi = ^bus.instruction[31:28];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (bus.wb_we) begin
            rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign rs_val = (bus.wb_we && bus.wb_rd == rs) ? bus.wb_data : rf[rs];
    assign rt_val = (bus.wb_we && bus.wb_rd == rt) ? bus.wb_data : rf[rt];
    assign svpc   = bus.ctrl[CTRL_SVPC];
    assign op1    = svpc ? bus.pc : rs_val;
    assign imm    = {{(DATA_W-IMM_W){bus.instruction[IMM_W-1]}}, bus.instruction[IMM_W-1:0]};

    logic              vld_q;
    logic [DATA_W-1:0] pc_q, rd1_q, rd2_q, imm_q;
    logic [REG_AW-1:0] rd_q;
    logic [CTRL_W-1:0] ctrl_q;

    // rs is not a real source when the PC is substituted, so it cannot cause a stall
    assign haz = bus.in_valid & vld_q & ctrl_q[CTRL_MEMR] &
                 (((rd_q == rs) & ~svpc) | (rd_q == rt));
    assign bus.stall = haz & ~bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            pc_q   <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            rd_q   <= '0;
            ctrl_q <= '0;
        end else if (bus.flush) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
        end else if (bus.hold) begin
            vld_q  <= vld_q;
        end else if (haz) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
        end else begin
            vld_q  <= bus.in_valid;
            pc_q   <= bus.pc;
            rd1_q  <= op1;
            rd2_q  <= rt_val;
            imm_q  <= imm;
            rd_q   <= rd;
            ctrl_q <= bus.in_valid ? bus.ctrl : '0;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_pc    = pc_q;
    assign bus.out_rd1   = rd1_q;
    assign bus.out_rd2   = rd2_q;
    assign bus.out_imm   = imm_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_ctrl  = ctrl_q;
endmodule

// File: tb/tb_id_stage_hazard.sv
// Randomized bench for id_stage_hazard with an instruction-level reference model.
module tb_id_stage_hazard;
    logic clk, rst_n;
    int   tests = 0, fails = 0;
    logic s_stall;

    id_stage_hazard_if #(.DATA_W(32), .REG_AW(6), .CTRL_W(12)) bus ();
    id_stage_hazard dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc, rd1, rd2, imm;
        logic [5:0]  rd;
        logic [11:0] ctrl;
    } idex_t;

    logic [31:0] m_rf [64];
    idex_t       q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_rf[i] = 32'h0;
        q = '{default: '0};
    endtask

    function automatic logic [31:0] mk(input logic [5:0] rd, input logic [5:0] rs,
                                       input logic [5:0] rt, input logic [9:0] lo);
        return {4'h0, rd, rs, rt, lo};
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [11:0] ctrl, input logic fl, input logic hd,
                         input logic we, input logic [5:0] wrd, input logic [31:0] wd);
        bus.in_valid = v;  bus.pc = pc;    bus.instruction = ins; bus.ctrl = ctrl;
        bus.flush = fl;    bus.hold = hd;  bus.wb_we = we;  bus.wb_rd = wrd; bus.wb_data = wd;
    endtask

    // Entered at a falling edge with inputs driven; leaves at the next falling edge.
    task automatic cycle();
        logic [5:0]  rs, rt, rd;
        logic        sv, haz;
        logic [31:0] rsv, rtv;
        idex_t       nq;
        #1;
        rd  = bus.instruction[27:22];
        rs  = bus.instruction[21:16];
        rt  = bus.instruction[15:10];
        sv  = bus.ctrl[2];
        rsv = (bus.wb_we && bus.wb_rd == rs) ? bus.wb_data : m_rf[rs];
        rtv = (bus.wb_we && bus.wb_rd == rt) ? bus.wb_data : m_rf[rt];
        haz = bus.in_valid && q.valid && q.ctrl[1] && ((!sv && q.rd == rs) || q.rd == rt);
        s_stall = bus.stall;
        chk("stall", s_stall, haz && !bus.flush);
        nq = q;
        if (bus.flush) begin
            nq.valid = 1'b0; nq.ctrl = '0;
        end else if (bus.hold) begin
            nq = q;
        end else if (haz) begin
            nq.valid = 1'b0; nq.ctrl = '0;
        end else begin
            nq.valid = bus.in_valid;
            nq.pc    = bus.pc;
            nq.rd1   = sv ? bus.pc : rsv;
            nq.rd2   = rtv;
            nq.imm   = {10'h0, bus.instruction[21:0]} - (bus.instruction[21] ? 32'h0040_0000 : 32'h0);
            nq.rd    = rd;
            nq.ctrl  = bus.in_valid ? bus.ctrl : 12'h0;
        end
        @(posedge clk);
        if (bus.wb_we) m_rf[bus.wb_rd] = bus.wb_data;
        q = nq;
        #1;
        chk("out_valid", bus.out_valid, q.valid);
        chk("out_ctrl", bus.out_ctrl, q.ctrl);
        if (q.valid) begin
            chk("out_pc", bus.out_pc, q.pc);
            chk("out_rd1", bus.out_rd1, q.rd1);
            chk("out_rd2", bus.out_rd2, q.rd2);
            chk("out_imm", bus.out_imm, q.imm);
            chk("out_rd", bus.out_rd, q.rd);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_rd1", bus.out_rd1, 0);
        chk("rst_imm", bus.out_imm, 0);
        chk("rst_ctrl", bus.out_ctrl, 0);
        rst_n = 1'b1;

        // write r5 with bypass, then read it back from the file
        drive(1, 32'h100, mk(6'd1, 6'd5, 6'd0, 0), 12'h0, 0, 0, 1, 6'd5, 32'hDEADBEEF);
        cycle();
        chk("bypass_rd1", bus.out_rd1, 32'hDEADBEEF);
        drive(1, 32'h104, mk(6'd1, 6'd5, 6'd0, 0), 12'h0, 0, 0, 0, 6'd0, 32'h0);
        cycle();
        chk("rf_rd1", bus.out_rd1, 32'hDEADBEEF);

        // sign-extended immediate and PC substitution
        drive(1, 32'h40, 32'h003F_FFFF, 12'h4, 0, 0, 0, 6'd0, 32'h0);
        cycle();
        chk("imm_sext", bus.out_imm, 32'hFFFF_FFFF);
        chk("svpc_rd1", bus.out_rd1, 32'h40);

        // load r7, then consumer on rt=7: one stall cycle, one bubble, then issue
        drive(1, 32'h50, mk(6'd7, 6'd1, 6'd2, 0), 12'h3, 0, 0, 0, 6'd0, 32'h0);
        cycle();
        drive(1, 32'h54, mk(6'd3, 6'd1, 6'd7, 0), 12'h1, 0, 0, 0, 6'd0, 32'h0);
        cycle();
        chk("lu_stall_first", s_stall, 1);
        chk("lu_bubble", bus.out_valid, 0);
        cycle();
        chk("lu_stall_second", s_stall, 0);
        chk("lu_issue", bus.out_valid, 1);
        chk("lu_issue_pc", bus.out_pc, 32'h54);

        // flush beats hold
        drive(1, 32'h60, mk(6'd2, 6'd1, 6'd1, 0), 12'h1, 1, 1, 0, 6'd0, 32'h0);
        cycle();
        chk("flush_hold_valid", bus.out_valid, 0);
        chk("flush_hold_ctrl", bus.out_ctrl, 0);
        // flush masks the stall of a load-use pair
        drive(1, 32'h70, mk(6'd7, 6'd1, 6'd2, 0), 12'h3, 0, 0, 0, 6'd0, 32'h0);
        cycle();
        drive(1, 32'h74, mk(6'd3, 6'd1, 6'd7, 0), 12'h1, 1, 0, 0, 6'd0, 32'h0);
        cycle();
        chk("flush_haz_stall", s_stall, 0);

        // hold for three cycles with changing inputs
        drive(1, 32'h200, mk(6'd4, 6'd5, 6'd5, 0), 12'h1, 0, 0, 0, 6'd0, 32'h0);
        cycle();
        chk("hold_load_pc", bus.out_pc, 32'h200);
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h204 + 32'(k) * 4, mk(6'(k), 6'd1, 6'd2, 10'(k)), 12'h1, 0, 1, 0, 6'd0, 32'h0);
            cycle();
            chk("hold_pc", bus.out_pc, 32'h200);
        end
        drive(1, 32'h300, mk(6'd9, 6'd5, 6'd5, 0), 12'h1, 0, 0, 0, 6'd0, 32'h0);
        cycle();
        chk("release_pc", bus.out_pc, 32'h300);

        // asynchronous reset mid-cycle with a valid entry in ID/EX
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", bus.out_valid, 0);
        chk("async_pc", bus.out_pc, 0);
        chk("async_rd1", bus.out_rd1, 0);
        chk("async_rd", bus.out_rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(1, 32'h10, mk(6'd1, 6'd5, 6'd5, 0), 12'h0, 0, 0, 0, 6'd0, 32'h0);
        cycle();
        chk("r5_after_reset", bus.out_rd1, 0);

        // randomized traffic; fetch keeps its instruction while stalled most of the time
        for (int n = 0; n < 3000; n++) begin
            if (!s_stall || $urandom_range(0, 3) == 0) begin
                bus.in_valid    = ($urandom_range(0, 9) < 8);
                bus.pc          = $urandom;
                bus.instruction = {4'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                                   6'($urandom_range(0, 7)), 10'($urandom)};
                bus.ctrl        = 12'($urandom);
            end
            bus.flush   = ($urandom_range(0, 9) == 0);
            bus.hold    = ($urandom_range(0, 4) == 0);
            bus.wb_we   = 1'($urandom_range(0, 1));
            bus.wb_rd   = 6'($urandom_range(0, 7));
            bus.wb_data = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
